vec_alu_sequencer: RTL and testbench
====================================

Name: vec_alu_sequencer

Overview:
- Consumes the decoded ALU control word (opALU, operALUe, operALUve, operSum) and executes it over multiple cycles.
- Scalar operations complete in one execute cycle and produce a scalar result.
- Vector operations iterate lane-by-lane over a combinational vector-register read port and write results back one lane per cycle.
- Sits between the control decoder and the vector register file / scalar writeback in the execute stage.

Parameters:
- LANES, 4, number of vector elements per operation (power of two, >=2)
- DATA_W, 8, element and scalar width
- VREG_W, 3, vector register select width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command valid
- ready  out  1  high only in IDLE; command accepted when start && ready
- opALU  in  3  operation code
- operALUe  in  1  scalar-scalar class
- operALUve  in  1  vector-scalar class
- operSum  in  1  vector-vector class
- scal_a  in  DATA_W  scalar operand A
- scal_b  in  DATA_W  scalar operand B
- vs1_sel, vs2_sel, vd_sel  in  VREG_W each  source and destination vector registers
- rd_sel1, rd_sel2  out  VREG_W  latched vs1/vs2 to the register file
- rd_lane  out  log2(LANES)  lane being read
- va_data, vb_data  in  DATA_W  combinational read data for rd_lane
- wr_en  out  1  vector lane write strobe
- wr_sel  out  VREG_W  latched vd
- wr_lane  out  log2(LANES)  lane written
- wr_data  out  DATA_W  lane result
- sres_valid  out  1  one-cycle scalar result strobe
- sres  out  DATA_W  scalar result, held until next scalar op
- done  out  1  one-cycle completion pulse
- busy  out  1  equals !ready

Behaviour:
- Reset: state=IDLE, ready=1, busy=0, wr_en=0, sres_valid=0, done=0, sres=0, wr_data=0, wr_lane=0, rd_lane=0, all latched selects=0.
- FSM states: IDLE, SCALAR, VEC, FIN.
- IDLE: on accept, latch all command inputs and go to the class state.
  - Class priority is operSum > operALUve > operALUe.
  - No class flag set (NOP) goes straight to FIN.
  - start while not in IDLE is ignored and has no effect.
- SCALAR: one cycle. Registered sres and sres_valid=1 appear at the next edge, then go to FIN.
  - 000: sres=b
  - 010: sres=a+b
  - 011: sres=a-b
  - 111: sres=a*b
  - Other codes: sres=0
- VEC: lane counter starts at 0. rd_lane=counter combinationally; each cycle register wr_en=1, wr_lane=counter, wr_data=f(lane).
  - 001: wr_data=a
  - 100: wr_data=va*a
  - 101: wr_data=va+vb
  - 110: wr_data=va/a, unsigned; a==0 gives all ones
  - Other codes: wr_data=va
  - After lane LANES-1 go to FIN. The counter wraps to 0.
- FIN: done=1 for exactly one cycle; ready returns high the following cycle.
- Arithmetic: unsigned, truncated modulo 2^DATA_W; no saturation, no flags.
- Latency, accept at edge T:
  - Scalar: sres_valid at T+1, done at T+2.
  - Vector: wr_en at T+1..T+LANES, done at T+LANES+1.
  - NOP: done at T+1.
- Back-to-back: the next command can be accepted no earlier than the cycle after done.
- Reset asserted mid-operation: immediate return to reset values; no further wr_en, and no done for the aborted command.

Test Plan:
- Reset with start held high: ready=1 and all strobes 0 until rst_n deasserted; first accept on the following edge.
- Scalar add, a=200, b=100, opALU=010, e=1: sres=44 (wrap) with one sres_valid pulse; done 2 cycles after accept; wr_en never asserted.
- Vector-vector add, opALU=101, sum=1, va={1,2,3,250}, vb={4,5,6,10}: writes lanes 0..3 as 5,7,9,4 on consecutive cycles to wr_sel=vd; done at T+5.
- Vector/scalar divide, opALU=110, ve=1, a=0 then a=3 with va={9,10,0,255}: first gives 255 on all lanes; second gives 3,3,0,85.
- NOP (all class flags 0, opALU=111): no writes, no sres_valid, done at T+1; start pulsed during a vector op is ignored and its operands never latched.
- rst_n dropped after lane 1 of a 4-lane op: wr_en low immediately, no done, ready=1 after release; a new command then runs normally from lane 0.

Source files
------------

// File: rtl/vec_alu_sequencer_if.sv
// vec_alu_sequencer_if: command, register-file and result signals of the ALU sequencer
interface vec_alu_sequencer_if #(
  parameter int LANES = 4,
  parameter int DATA_W = 8,
  parameter int VREG_W = 3
);
  localparam int LW = $clog2(LANES);
  logic start, ready, busy, operALUe, operALUve, operSum, wr_en, sres_valid, done;
  logic [2:0] opALU;
  logic [DATA_W-1:0] scal_a, scal_b, va_data, vb_data, wr_data, sres;
  logic [VREG_W-1:0] vs1_sel, vs2_sel, vd_sel, rd_sel1, rd_sel2, wr_sel;
  logic [LW-1:0] rd_lane, wr_lane;
  modport slave (
    input start, opALU, operALUe, operALUve, operSum, scal_a, scal_b, vs1_sel, vs2_sel, vd_sel, va_data, vb_data,
    output ready, busy, rd_sel1, rd_sel2, rd_lane, wr_en, wr_sel, wr_lane, wr_data, sres_valid, sres, done
  );
  modport master (
    output start, opALU, operALUe, operALUve, operSum, scal_a, scal_b, vs1_sel, vs2_sel, vd_sel, va_data, vb_data,
    input ready, busy, rd_sel1, rd_sel2, rd_lane, wr_en, wr_sel, wr_lane, wr_data, sres_valid, sres, done
  );
endinterface

// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: multi-cycle execute sequencer for scalar and lane-by-lane vector ALU ops
module vec_alu_sequencer #(
  parameter int LANES = 4,
  parameter int DATA_W = 8,
  parameter int VREG_W = 3
) (
  input logic clk,
  input logic rst_n,
  vec_alu_sequencer_if.slave bus
);
  localparam int LW = $clog2(LANES);
  typedef enum logic [1:0] {IDLE, SCALAR, VEC, FIN} state_t;
  state_t state, state_nxt;
  logic [2:0] op;
  logic [DATA_W-1:0] a, b, va, sres_nxt, lane_nxt;
  logic [VREG_W-1:0] vs1, vs2, vd;
  logic [LW-1:0] cnt;
  logic done_q, accept;
  assign va = bus.va_data;
  assign bus.ready = state == IDLE && !done_q;
  assign bus.busy = !bus.ready;
  assign bus.done = done_q;
  assign accept = bus.start && bus.ready;
  assign bus.rd_lane = cnt;
  assign bus.rd_sel1 = vs1;
  assign bus.rd_sel2 = vs2;
  assign bus.wr_sel = vd;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: vector classes outrank the scalar class, no class flag falls straight to FIN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (bus.operSum || bus.operALUve) ? VEC : bus.operALUe ? SCALAR : FIN;
      SCALAR: state_nxt = FIN;
      VEC: if (cnt == LW'(LANES - 1)) state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end
  // scalar result and per-lane result, truncated to DATA_W
  always_comb begin
    sres_nxt = op == 3'b000 ? b : op == 3'b010 ? a + b : op == 3'b011 ? a - b : op == 3'b111 ? a * b : '0;
    lane_nxt = op == 3'b001 ? a : op == 3'b100 ? va * a : op == 3'b101 ? va + bus.vb_data :
               op == 3'b110 ? (a == '0 ? '1 : va / a) : va;
  end
  // command latch, lane counter and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op <= '0;
      a <= '0;
      b <= '0;
      vs1 <= '0;
      vs2 <= '0;
      vd <= '0;
      cnt <= '0;
      done_q <= 1'b0;
      bus.wr_en <= 1'b0;
      bus.wr_lane <= '0;
      bus.wr_data <= '0;
      bus.sres_valid <= 1'b0;
      bus.sres <= '0;
    end else begin
      bus.wr_en <= state == VEC;
      bus.sres_valid <= state == SCALAR;
      done_q <= state == FIN;
      if (accept) begin
        op <= bus.opALU;
        a <= bus.scal_a;
        b <= bus.scal_b;
        vs1 <= bus.vs1_sel;
        vs2 <= bus.vs2_sel;
        vd <= bus.vd_sel;
      end
      if (state == SCALAR) bus.sres <= sres_nxt;
      if (state == VEC) begin
        bus.wr_lane <= cnt;
        bus.wr_data <= lane_nxt;
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_vec_alu_sequencer.sv
// tb_vec_alu_sequencer: directed and random stimulus checked against a schedule-based reference model
module tb_vec_alu_sequencer;
  localparam int LANES = 4, DATA_W = 8, VREG_W = 3;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  vec_alu_sequencer_if #(.LANES(LANES), .DATA_W(DATA_W), .VREG_W(VREG_W)) bus();
  vec_alu_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .VREG_W(VREG_W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [7:0] vreg [8][4];
  assign bus.va_data = vreg[bus.rd_sel1][bus.rd_lane];
  assign bus.vb_data = vreg[bus.rd_sel2][bus.rd_lane];
  typedef struct packed {logic [1:0] lane; logic [7:0] data; logic [2:0] sel;} wr_t;
  wr_t e_wr[int];
  logic [7:0] e_sv[int];
  bit e_done[int];
  int cyc = 0, free_from = 0, acc_cyc = -1, done_cyc = -1, wr_cnt = 0, n_chk = 0, n_err = 0;
  logic [7:0] sres_m = 0;
  logic [7:0] cap [4];
  function automatic logic [7:0] sfun(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return b;
      3'd2: return a + b;
      3'd3: return a - b;
      3'd7: return a * b;
      default: return 8'd0;
    endcase
  endfunction
  function automatic logic [7:0] vfun(input logic [2:0] op, input logic [7:0] a, input logic [7:0] va, input logic [7:0] vb);
    case (op)
      3'd1: return a;
      3'd4: return va * a;
      3'd5: return va + vb;
      3'd6: return a == 8'd0 ? 8'hFF : va / a;
      default: return va;
    endcase
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask
  task automatic model_reset();
    e_wr.delete();
    e_sv.delete();
    e_done.delete();
    free_from = 0;
    sres_m = 0;
  endtask
  // reference model: on each accepted command, schedule every expected output by interval number
  initial forever begin
    int t;
    @(posedge clk);
    if (rst_n && bus.start && cyc >= free_from) begin
      t = cyc + 1;
      acc_cyc = t;
      if (bus.operSum || bus.operALUve) begin
        for (int i = 0; i < LANES; i++)
          e_wr[t + 1 + i] = '{lane: 2'(i), data: vfun(bus.opALU, bus.scal_a, vreg[bus.vs1_sel][i], vreg[bus.vs2_sel][i]), sel: bus.vd_sel};
        e_done[t + LANES + 1] = 1;
        free_from = t + LANES + 2;
      end else if (bus.operALUe) begin
        e_sv[t + 1] = sfun(bus.opALU, bus.scal_a, bus.scal_b);
        e_done[t + 2] = 1;
        free_from = t + 3;
      end else begin
        e_done[t + 1] = 1;
        free_from = t + 2;
      end
    end
    cyc++;
  end
  // compare process: every interval, DUT outputs against the model schedule
  initial forever begin
    int k;
    @(negedge clk);
    k = cyc;
    if (!rst_n) begin
      chk("rst_ready", bus.ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_sres_valid", bus.sres_valid, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_sres", bus.sres, 0);
      chk("rst_wr_data", bus.wr_data, 0);
      chk("rst_wr_lane", bus.wr_lane, 0);
      chk("rst_rd_lane", bus.rd_lane, 0);
      chk("rst_sels", {bus.rd_sel1, bus.rd_sel2, bus.wr_sel}, 0);
    end else begin
      chk("ready", bus.ready, k >= free_from);
      chk("busy", bus.busy, k < free_from);
      chk("wr_en", bus.wr_en, e_wr.exists(k));
      if (bus.wr_en) begin
        wr_cnt++;
        cap[bus.wr_lane] = bus.wr_data;
        if (e_wr.exists(k)) begin
          chk("wr_lane", bus.wr_lane, e_wr[k].lane);
          chk("wr_data", bus.wr_data, e_wr[k].data);
          chk("wr_sel", bus.wr_sel, e_wr[k].sel);
        end
      end
      if (e_sv.exists(k)) sres_m = e_sv[k];
      chk("sres_valid", bus.sres_valid, e_sv.exists(k));
      chk("sres", bus.sres, sres_m);
      chk("done", bus.done, e_done.exists(k));
      if (bus.done) done_cyc = k;
    end
  end
  task automatic step();
    @(negedge clk);
    #2;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (cyc < free_from && n < 100) begin
      step();
      n++;
    end
    if (cyc < free_from) chk("idle_timeout", 1, 0);
  endtask
  task automatic drive(input logic [2:0] op, input logic e, input logic ve, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] v1, input logic [2:0] v2, input logic [2:0] vd);
    bus.opALU = op;
    bus.operALUe = e;
    bus.operALUve = ve;
    bus.operSum = s;
    bus.scal_a = a;
    bus.scal_b = b;
    bus.vs1_sel = v1;
    bus.vs2_sel = v2;
    bus.vd_sel = vd;
  endtask
  task automatic issue(input logic [2:0] op, input logic e, input logic ve, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] v1, input logic [2:0] v2, input logic [2:0] vd);
    wait_idle();
    drive(op, e, ve, s, a, b, v1, v2, vd);
    bus.start = 1;
    step();
    bus.start = 0;
  endtask
  task automatic clear_obs();
    wr_cnt = 0;
    done_cyc = -1;
    for (int i = 0; i < 4; i++) cap[i] = 8'h00;
  endtask
  initial begin
    int rel;
    for (int r = 0; r < 8; r++) for (int l = 0; l < 4; l++) vreg[r][l] = 8'h00;
    vreg[1] = '{8'd1, 8'd2, 8'd3, 8'd250};
    vreg[2] = '{8'd4, 8'd5, 8'd6, 8'd10};
    vreg[3] = '{8'd9, 8'd10, 8'd0, 8'd255};
    clear_obs();
    drive(3'b010, 1, 0, 0, 8'd200, 8'd100, 3'd0, 3'd0, 3'd0);
    bus.start = 1;
    repeat (3) step();
    rst_n = 1;
    rel = cyc;
    step();
    bus.start = 0;
    wait_idle();
    chk("first_accept_done", done_cyc, rel + 3);
    chk("add_wrap_sres", bus.sres, 44);
    chk("scalar_latency", done_cyc - acc_cyc, 2);
    chk("scalar_no_writes", wr_cnt, 0);
    clear_obs();
    issue(3'b101, 0, 0, 1, 8'd0, 8'd0, 3'd1, 3'd2, 3'd5);
    wait_idle();
    chk("vv_add_lanes", {cap[0], cap[1], cap[2], cap[3]}, {8'd5, 8'd7, 8'd9, 8'd4});
    chk("vv_latency", done_cyc - acc_cyc, 5);
    chk("vv_writes", wr_cnt, 4);
    clear_obs();
    issue(3'b110, 0, 1, 0, 8'd0, 8'd0, 3'd3, 3'd0, 3'd4);
    wait_idle();
    chk("div0_lanes", {cap[0], cap[1], cap[2], cap[3]}, 32'hFFFFFFFF);
    clear_obs();
    issue(3'b110, 0, 1, 0, 8'd3, 8'd0, 3'd3, 3'd0, 3'd4);
    wait_idle();
    chk("div3_lanes", {cap[0], cap[1], cap[2], cap[3]}, {8'd3, 8'd3, 8'd0, 8'd85});
    clear_obs();
    issue(3'b111, 0, 0, 0, 8'd7, 8'd9, 3'd0, 3'd0, 3'd0);
    wait_idle();
    chk("nop_latency", done_cyc - acc_cyc, 1);
    chk("nop_no_writes", wr_cnt, 0);
    clear_obs();
    issue(3'b100, 0, 1, 0, 8'd3, 8'd0, 3'd1, 3'd0, 3'd2);
    repeat (3) begin
      drive(3'($urandom), 1, 1, 1, 8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom), 3'd7);
      bus.start = 1;
      step();
    end
    bus.start = 0;
    wait_idle();
    chk("ignored_start_lanes", {cap[0], cap[1], cap[2], cap[3]}, {8'd3, 8'd6, 8'd9, 8'd238});
    chk("ignored_start_writes", wr_cnt, 4);
    clear_obs();
    issue(3'b101, 0, 0, 1, 8'd0, 8'd0, 3'd1, 3'd2, 3'd3);
    repeat (2) step();
    rst_n = 0;
    model_reset();
    #1;
    chk("abort_wr_en_now", bus.wr_en, 0);
    chk("abort_ready_now", bus.ready, 1);
    chk("abort_writes", wr_cnt, 2);
    repeat (2) step();
    rst_n = 1;
    #1;
    chk("abort_ready_after", bus.ready, 1);
    chk("abort_no_done", done_cyc, -1);
    step();
    clear_obs();
    issue(3'b001, 0, 1, 0, 8'h5A, 8'd0, 3'd1, 3'd0, 3'd6);
    wait_idle();
    chk("post_abort_lanes", {cap[0], cap[1], cap[2], cap[3]}, 32'h5A5A5A5A);
    chk("post_abort_latency", done_cyc - acc_cyc, 5);
    for (int r = 0; r < 8; r++) for (int l = 0; l < 4; l++) vreg[r][l] = 8'($urandom);
    repeat (600) begin
      drive(3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      bus.start = $urandom_range(0, 2) == 0;
      step();
    end
    bus.start = 0;
    wait_idle();
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
